// File: rtl/serial_bit_tx.sv
// serial_bit_tx
//   Parallel-to-serial transmitter. Accepts one WIDTH-bit word per
//   valid/ready handshake and emits it one bit per clock with en high,
//   LSB first (MSB_FIRST = 0) or MSB first (MSB_FIRST = 1). Back-to-back
//   words stream with no idle cycle between them.
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset
//     in_valid  in   in_data holds a word to send
//     in_ready  out  word can be accepted this cycle (combinational)
//     in_data   in   WIDTH-bit word, sampled only on the accept edge
//     en        out  serial bit enable, high exactly while d carries payload
//     d         out  serial data bit, 0 whenever en = 0
//     busy      out  a word is in transmission
//     done      out  high during the cycle carrying the last bit of a word
//
//   state | meaning
//   IDLE  | no word in flight, en/d/busy/done low, ready for a word
//   SHIFT | bit cnt of the current word is on d
module serial_bit_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             en,
    output logic             d,
    output logic             busy,
    output logic             done
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam int            OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] sr;
    logic             last;
    logic             accept;

    assign cnt_inc = cnt + CW'(1);
    assign last    = (state == SHIFT) && (cnt == LAST);
    // Gated by rst_n so no handshake can complete while reset is held.
    assign in_ready = rst_n && ((state == IDLE) || last);
    assign accept   = in_valid && in_ready;

    // The shift register is cleared whenever the FSM goes idle, so its
    // output tap reads 0 outside SHIFT without extra gating.
    assign d = sr[OUT_IDX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (accept) begin
            // Covers both the idle accept and the reload on the last bit.
            state <= SHIFT;
            sr    <= in_data;
            cnt   <= '0;
            en    <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state <= IDLE;
                sr    <= '0;
                cnt   <= '0;
                en    <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                sr   <= MSB_FIRST ? (sr << 1) : (sr >> 1);
                cnt  <= cnt_inc;
                done <= (cnt_inc == LAST);
            end
        end
    end

endmodule

// File: doc/serial_bit_tx.md
# serial_bit_tx

Parallel-to-serial transmitter producing the gated single-bit stream (`en`, `d`) consumed by the team's registered enable-gated bit stages. It accepts one `WIDTH`-bit word per valid/ready handshake and emits it one bit per clock with `en` high, LSB first by default. Back-to-back words stream without idle cycles. `en` and `d` are both 0 whenever no word is being transmitted.

## Interface

- `WIDTH`, default 8: word width in bits; legal values are 2 and above.
- `MSB_FIRST`, default 0: 0 sends bit 0 first; 1 sends bit `WIDTH-1` first.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` holds a word to send.
- `in_ready`  out  1: the block can accept a word this cycle.
- `in_data`  in  WIDTH: word to serialize; sampled only on the accept edge.
- `en`  out  1: serial bit enable; 1 exactly when `d` carries a payload bit.
- `d`  out  1: serial data bit; 0 whenever `en` = 0.
- `busy`  out  1: a word is in transmission (state SHIFT).
- `done`  out  1: high during the cycle that carries the last bit of a word.

## Operation

- **State machine:**
  - Two states: IDLE and SHIFT.
  - Internal state: shift register of `WIDTH` bits and a bit counter of `$clog2(WIDTH)` bits.
- **Accept:** a word is accepted on a rising edge where `in_valid` && `in_ready`.
  - The shift register loads `in_data`.
  - The counter is set to 0.
  - The state goes to SHIFT.
- **`in_ready`** is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when the counter equals `WIDTH-1` (last bit).
  - 0 otherwise, and forced to 0 while `rst_n` = 0.
- **SHIFT, each cycle:**
  - `en` = 1.
  - `d` = the current output bit of the shift register: LSB when `MSB_FIRST` = 0, MSB when `MSB_FIRST` = 1.
  - On the edge, the register shifts toward the output end and the counter increments.
- **Last bit (counter = `WIDTH-1`):**
  - If a new word is accepted on this edge, reload and stay in SHIFT with the counter at 0.
  - Otherwise go to IDLE.
- **IDLE:** `en` = 0, `d` = 0, `busy` = 0, `done` = 0.
- `en`, `d`, `busy` and `done` are all registered or decoded from registered state only; no input-to-output combinational path.
- `in_data` and `in_valid` are ignored when `in_ready` = 0; an upstream word held valid during SHIFT stays pending.
- **Reset (asynchronous, any time, including mid-word):**
  - State goes to IDLE and the counter to 0.
  - `en` = 0, `d` = 0, `busy` = 0, `done` = 0 immediately.
  - A partially sent word is discarded, not resumed.
  - After `rst_n` rises, `in_ready` = 1 in the first cycle.

## Timing

- Accept at edge k: bit i appears on `d` with `en` = 1 in the cycle after edge k+i, for i = 0..`WIDTH-1`.
- Latency from accept edge to first bit: 1 cycle.
- Word occupies exactly `WIDTH` consecutive `en` cycles.
- `done` = 1 and `in_ready` = 1 together in the cycle of bit `WIDTH-1`.
- Continuous stream: if `in_valid` is held high, throughput is one bit per cycle with no gap between words.
- No new word at the last-bit edge: in the next cycle `en` = 0, `d` = 0, `busy` = 0.
- Maximum idle gap between a word and the next accept is unbounded. Minimum gap is 0.

## Test plan

- **Single word, LSB first:**
  - Stimulus: `WIDTH`=8, `MSB_FIRST`=0, `in_data`=8'hC1, `in_valid` pulsed for one cycle in IDLE.
  - Required: `d` = 1,0,0,0,0,0,1,1 over 8 cycles with `en` = 1; `done` only on the 8th; then `en` = 0, `d` = 0.
- **Single word, MSB first:**
  - Stimulus: `MSB_FIRST`=1, `in_data`=8'hC1.
  - Required: `d` = 1,1,0,0,0,0,0,1; the 8th cycle has `done` = 1.
- **Back-to-back words:**
  - Stimulus: 8'hA5 then 8'h3C with `in_valid` held high.
  - Required: 16 consecutive `en` = 1 cycles with `d` = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; `done` pulses at cycles 8 and 16; `in_ready` is high only at the first accept and at cycles 8 and 16.
- **Backpressure:**
  - Stimulus: `in_valid` held high during SHIFT with `in_data` changing every cycle.
  - Required: no accept until the last-bit cycle; the word sampled there is the one transmitted next.
- **Reset mid-word:**
  - Stimulus: drop `rst_n` during bit 3 of 8'hFF, asynchronously between edges.
  - Required: `en`, `d`, `busy` and `in_ready` go to 0 before the next edge. After release, `in_ready` = 1 and a new word 8'h01 transmits as 1,0,0,0,0,0,0,0.
- **Minimum width:**
  - Stimulus: `WIDTH`=2, words 2'b10 and 2'b01 streamed.
  - Required: `d` = 0,1,1,0, with `done` high on cycles 2 and 4.
